// File: rtl/pacman_int_ctrl.sv
// Pac-Man Z80 maskable-interrupt responder.
//
// Generates the periodic (vblank-rate) interrupt request and gates it with the
// memory-mapped interrupt-enable latch. The IM2 vector written by the CPU to an
// I/O port is held here and driven onto the CPU data-in mux during the Z80
// interrupt-acknowledge cycle.
//
// Ports:
//   clk, rst      - system clock; asynchronous active-high reset
//   cpu_A         - tv80s address bus
//   cpu_dout      - tv80s write data
//   cpu_m1_n      - tv80s M1 (active-low)
//   cpu_mreq_n    - tv80s MREQ (active-low)
//   cpu_iorq_n    - tv80s IORQ (active-low)
//   cpu_wr_n      - tv80s WR (active-low)
//   cpu_int_n     - interrupt request to tv80s (active-low)
//   int_di        - vector byte for the cpu_di mux
//   int_di_valid  - selects int_di over rom/ram in the cpu_di mux
//   int_en        - interrupt-enable latch state
//   tick_overrun  - sticky: a timer tick was lost
module pacman_int_ctrl #(
  parameter int unsigned TICK_CYCLES = 100000,
  parameter logic [15:0] INT_EN_ADDR = 16'h5000,
  parameter logic [7:0]  VEC_PORT    = 8'h00,
  parameter logic [7:0]  VEC_RESET   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_A,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_m1_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_wr_n,
  output logic        cpu_int_n,
  output logic [7:0]  int_di,
  output logic        int_di_valid,
  output logic        int_en,
  output logic        tick_overrun
);

  localparam logic [17:0] TickLast = 18'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPend, StAck} state_e;

  state_e      state_q;
  logic [17:0] cnt_q;
  logic        tick;
  logic        mem_wr_c, io_wr_c, ack_c;
  logic        mem_wr_q, io_wr_q, ack_q;
  logic        mem_wr_ev, io_wr_ev, ack_ev;
  logic        int_en_q;
  logic [7:0]  vec_q;
  logic        pending_q;
  logic        int_n_q;
  logic        valid_q;
  logic [7:0]  di_q;
  logic        overrun_q;

  // Bus strobe conditions (levels).
  assign mem_wr_c = !cpu_mreq_n && !cpu_wr_n && (cpu_A == INT_EN_ADDR);
  assign io_wr_c  = !cpu_iorq_n && !cpu_wr_n && cpu_m1_n && (cpu_A[7:0] == VEC_PORT);
  assign ack_c    = !cpu_m1_n && !cpu_iorq_n;

  // Events fire only in the first cycle a condition holds.
  assign mem_wr_ev = mem_wr_c && !mem_wr_q;
  assign io_wr_ev  = io_wr_c && !io_wr_q;
  assign ack_ev    = ack_c && !ack_q;

  assign tick = (cnt_q == TickLast);

  // Strobe history, timer, enable latch and vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_q <= 1'b0;
      io_wr_q  <= 1'b0;
      ack_q    <= 1'b0;
      cnt_q    <= '0;
      int_en_q <= 1'b0;
      vec_q    <= VEC_RESET;
    end else begin
      mem_wr_q <= mem_wr_c;
      io_wr_q  <= io_wr_c;
      ack_q    <= ack_c;
      cnt_q    <= tick ? '0 : cnt_q + 18'd1;
      if (mem_wr_ev) int_en_q <= cpu_dout[0];
      if (io_wr_ev)  vec_q    <= cpu_dout;
    end
  end

  // Request / acknowledge FSM with registered outputs. All decisions use the
  // pre-edge int_en and vector, so a same-cycle write is seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      int_n_q   <= 1'b1;
      valid_q   <= 1'b0;
      di_q      <= VEC_RESET;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // A tick while disabled is simply dropped; a pending tick waits for
          // the enable to return.
          if (int_en_q && (tick || pending_q)) begin
            state_q   <= StPend;
            int_n_q   <= 1'b0;
            pending_q <= 1'b0;
          end
        end
        StPend: begin
          if (tick) overrun_q <= 1'b1;
          if (ack_ev) begin
            state_q <= StAck;
            di_q    <= vec_q;
            valid_q <= 1'b1;
            int_n_q <= 1'b1;
          end else if (!int_en_q) begin
            state_q <= StIdle;
            int_n_q <= 1'b1;
          end
        end
        StAck: begin
          // One-deep queue for ticks arriving while the vector is on the bus.
          if (!int_en_q) begin
            pending_q <= 1'b0;
          end else if (tick) begin
            if (pending_q) overrun_q <= 1'b1;
            else           pending_q <= 1'b1;
          end
          if (!ack_c) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_int_n    = int_n_q;
  assign int_di       = di_q;
  assign int_di_valid = valid_q;
  assign int_en       = int_en_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_pacman_int_ctrl.sv
module tb_pacman_int_ctrl;

  localparam int T = 16;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        wr_n;
  } bus_t;

  // exp = {cpu_int_n, int_di_valid, int_en, tick_overrun, int_di}
  typedef struct packed {
    bus_t        b;
    logic [11:0] exp;
  } row_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_A;
  logic [7:0]  cpu_dout;
  logic        cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_wr_n;
  logic        cpu_int_n;
  logic [7:0]  int_di;
  logic        int_di_valid;
  logic        int_en;
  logic        tick_overrun;
  logic [11:0] outs_now;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  pacman_int_ctrl #(
    .TICK_CYCLES(T),
    .INT_EN_ADDR(16'h5000),
    .VEC_PORT   (8'h00),
    .VEC_RESET  (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_A       (cpu_A),
    .cpu_dout    (cpu_dout),
    .cpu_m1_n    (cpu_m1_n),
    .cpu_mreq_n  (cpu_mreq_n),
    .cpu_iorq_n  (cpu_iorq_n),
    .cpu_wr_n    (cpu_wr_n),
    .cpu_int_n   (cpu_int_n),
    .int_di      (int_di),
    .int_di_valid(int_di_valid),
    .int_en      (int_en),
    .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  assign outs_now = {cpu_int_n, int_di_valid, int_en, tick_overrun, int_di};

  // ---------------------------------------------------------------- helpers
  function automatic bus_t mkb(input logic [15:0] a, input logic [7:0] d,
                               input logic m1, input logic mreq, input logic iorq,
                               input logic wr);
    bus_t b;
    b.a = a; b.d = d; b.m1_n = m1; b.mreq_n = mreq; b.iorq_n = iorq; b.wr_n = wr;
    return b;
  endfunction

  function automatic bus_t b_idle();
    return mkb(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
  endfunction
  function automatic bus_t b_memwr(input logic [15:0] a, input logic [7:0] d);
    return mkb(a, d, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic bus_t b_iowr(input logic [15:0] a, input logic [7:0] d);
    return mkb(a, d, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic bus_t b_inta();
    return mkb(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction

  task automatic set_bus(input bus_t b);
    cpu_A      = b.a;
    cpu_dout   = b.d;
    cpu_m1_n   = b.m1_n;
    cpu_mreq_n = b.mreq_n;
    cpu_iorq_n = b.iorq_n;
    cpu_wr_n   = b.wr_n;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outputs are sampled on the falling edge, one half-period after the edge
  // that produced them; inputs change on the falling edge too.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_bus(b_idle());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // ---------------------------------------------------------- reference model
  // Cycle k after reset carries a tick when k mod T == T-1; the model tracks
  // "a request is outstanding", "the vector is being served", "one tick is
  // queued" and "a tick was lost" directly from the behavioural rules.
  int          m_k;
  bit          m_en, m_req, m_serv, m_queued, m_lost;
  logic [7:0]  m_vec, m_di;

  function automatic bit is_mem_wr(input bus_t b);
    return !b.mreq_n && !b.wr_n && (b.a == 16'h5000);
  endfunction
  function automatic bit is_io_wr(input bus_t b);
    return !b.iorq_n && !b.wr_n && b.m1_n && (b.a[7:0] == 8'h00);
  endfunction
  function automatic bit is_ack(input bus_t b);
    return !b.m1_n && !b.iorq_n;
  endfunction

  task automatic model_reset();
    m_k = 0; m_en = 0; m_req = 0; m_serv = 0; m_queued = 0; m_lost = 0;
    m_vec = 8'hFF; m_di = 8'hFF;
  endtask

  task automatic model_step(input bus_t cur, input bus_t prev);
    bit tick, mem_ev, io_ev, ack_ev;
    tick   = (m_k % T) == (T - 1);
    mem_ev = is_mem_wr(cur) && !is_mem_wr(prev);
    io_ev  = is_io_wr(cur) && !is_io_wr(prev);
    ack_ev = is_ack(cur) && !is_ack(prev);
    if (m_serv) begin
      if (!m_en) m_queued = 0;
      else if (tick) begin
        if (m_queued) m_lost = 1;
        else          m_queued = 1;
      end
      if (!is_ack(cur)) m_serv = 0;
    end else if (m_req) begin
      if (tick) m_lost = 1;
      if (ack_ev) begin
        m_req = 0; m_serv = 1; m_di = m_vec;
      end else if (!m_en) begin
        m_req = 0;
      end
    end else if (m_en && (tick || m_queued)) begin
      m_req = 1; m_queued = 0;
    end
    if (mem_ev) m_en = cur.d[0];
    if (io_ev)  m_vec = cur.d;
    m_k++;
  endtask

  function automatic logic [11:0] model_outs();
    return {~m_req, m_serv, m_en, m_lost, m_di};
  endfunction

  // ------------------------------------------------------------------- test
  row_t tbl [22];

  initial begin
    bit   saw_low;
    bus_t cur, prev;
    int   left;

    // Directed vectors from reset; tick lands in cycles 15, 31, ...
    tbl[0]  = '{b_idle(),                       12'h8FF};
    tbl[1]  = '{b_memwr(16'h5000, 8'h01),       12'hAFF};
    tbl[2]  = '{b_memwr(16'h5000, 8'h00),       12'hAFF}; // held: no new event
    tbl[3]  = '{b_idle(),                       12'hAFF};
    tbl[4]  = '{b_memwr(16'h5001, 8'h00),       12'hAFF}; // wrong address
    tbl[5]  = '{b_iowr(16'h5000, 8'h00),        12'hAFF}; // IO, not memory
    tbl[6]  = '{mkb(16'h5000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1), 12'hAFF}; // read
    tbl[7]  = '{b_memwr(16'h5000, 8'hFE),       12'h8FF}; // bit 0 only
    tbl[8]  = '{b_memwr(16'h5000, 8'h01),       12'h8FF}; // held
    tbl[9]  = '{b_idle(),                       12'h8FF};
    tbl[10] = '{b_memwr(16'h5000, 8'h03),       12'hAFF};
    tbl[11] = '{b_idle(),                       12'hAFF};
    tbl[12] = '{b_idle(),                       12'hAFF};
    tbl[13] = '{b_idle(),                       12'hAFF};
    tbl[14] = '{b_idle(),                       12'hAFF};
    tbl[15] = '{b_idle(),                       12'h2FF}; // tick -> request
    tbl[16] = '{b_iowr(16'h1200, 8'hCF),        12'h2FF};
    tbl[17] = '{b_idle(),                       12'h2FF};
    tbl[18] = '{b_inta(),                       12'hECF};
    tbl[19] = '{b_inta(),                       12'hECF};
    tbl[20] = '{b_inta(),                       12'hECF};
    tbl[21] = '{b_idle(),                       12'hACF};

    set_bus(b_idle());
    do_reset();
    check("reset_outputs", 32'(outs_now), 32'h8FF);
    for (int i = 0; i < 22; i++) begin
      set_bus(tbl[i].b);
      step();
      check($sformatf("tbl[%0d]", i), 32'(outs_now), 32'(tbl[i].exp));
    end

    // No enable write: no request for 200 cycles.
    do_reset();
    saw_low = 0;
    repeat (200) begin
      step();
      if (!cpu_int_n) saw_low = 1;
    end
    check("noen_int_n_high", 32'(saw_low), 32'd0);
    check("noen_overrun", 32'(tick_overrun), 32'd0);

    // Two ticks while pending: overrun, a single ack clears the request.
    do_reset();
    set_bus(b_memwr(16'h5000, 8'h01)); step();
    set_bus(b_idle()); run_to(16);
    check("ovr_req", 32'(cpu_int_n), 32'd0);
    run_to(32);
    check("ovr_flag", 32'(tick_overrun), 32'd1);
    check("ovr_still_req", 32'(cpu_int_n), 32'd0);
    set_bus(b_inta()); run_to(35);
    check("ovr_ack_outs", 32'(outs_now), 32'hFFF);
    set_bus(b_idle()); step();
    check("ovr_ack_done", 32'(outs_now), 32'hBFF);
    run_to(45);
    check("ovr_single_req", 32'(outs_now), 32'hBFF);

    // Enable cleared while pending: request withdrawn, INTA ignored.
    do_reset();
    set_bus(b_memwr(16'h5000, 8'h01)); step();
    set_bus(b_idle()); run_to(16);
    set_bus(b_memwr(16'h5000, 8'h00)); step();
    check("dis_pend_c16", 32'(outs_now), 32'h0FF);
    set_bus(b_idle()); step();
    check("dis_pend_c17", 32'(outs_now), 32'h8FF);
    set_bus(b_inta()); step(); step(); step();
    check("dis_no_ack", 32'(outs_now), 32'h8FF);

    // Disable written in the tick cycle: one-cycle request pulse.
    do_reset();
    set_bus(b_memwr(16'h5000, 8'h01)); step();
    set_bus(b_idle()); run_to(15);
    set_bus(b_memwr(16'h5000, 8'h00)); step();
    check("tickdis_pulse", 32'(outs_now), 32'h0FF);
    set_bus(b_idle()); step();
    check("tickdis_release", 32'(outs_now), 32'h8FF);
    saw_low = 0;
    while (cyc < 34) begin
      step();
      if (!cpu_int_n) saw_low = 1;
    end
    check("tickdis_dropped", 32'({saw_low, tick_overrun}), 32'd0);

    // Tick during a long acknowledge is queued and re-requested on exit.
    do_reset();
    set_bus(b_memwr(16'h5000, 8'h01)); step();
    set_bus(b_idle()); run_to(20);
    set_bus(b_inta()); run_to(34);
    check("queue_in_ack", 32'(outs_now), 32'hEFF);
    set_bus(b_idle()); step();
    check("queue_ack_exit", 32'(outs_now), 32'hAFF);
    step();
    check("queue_rereq", 32'(outs_now), 32'h2FF);

    // Asynchronous reset in the middle of an acknowledge.
    do_reset();
    set_bus(b_memwr(16'h5000, 8'h01)); step();
    set_bus(b_iowr(16'h0000, 8'hCF)); step();
    set_bus(b_idle()); run_to(16);
    set_bus(b_inta()); step();
    check("arst_pre", 32'(outs_now), 32'hECF);
    #2 rst = 1'b1;
    #1 check("arst_outputs", 32'(outs_now), 32'h8FF);
    @(negedge clk);

    // Randomized bus traffic against the reference model.
    do_reset();
    model_reset();
    prev = b_idle();
    cur  = b_idle();
    left = 0;
    for (int c = 0; c < 2500; c++) begin
      if (left == 0) begin
        int op;
        op   = $urandom_range(0, 9);
        left = $urandom_range(1, 4);
        if (op <= 3)      cur = b_idle();
        else if (op <= 5) cur = b_memwr(16'h5000, {7'($urandom), ($urandom_range(0, 3) != 0)});
        else if (op == 6) cur = b_iowr({8'($urandom), 8'h00}, 8'($urandom));
        else if (op <= 8) cur = b_inta();
        else cur = mkb(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom));
      end
      left--;
      set_bus(cur);
      model_step(cur, prev);
      prev = cur;
      step();
      check("random", 32'(outs_now), 32'(model_outs()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
